// File: rtl/npc_pkg.sv
// Shared NPC pipeline constants: register-file geometry defaults, the
// hard-wired zero-register index and the architectural register index type.
package npc_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned ZERO_REG       = 0;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;

endpackage : npc_pkg

// File: rtl/regfile_rport.sv
// One combinational read port of regfile_sb: zero mux, busy lookup and, when
// REGFILE_BYPASS_EN is defined, same-cycle writeback forwarding.
module regfile_rport
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int NREGS     = 2**ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] rf_i [NREGS],
  input  logic [NREGS-1:0]      busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
`endif
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rbusy_o
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rdata_o = '0;
    rbusy_o = 1'b0;
    if (raddr_i != ZERO_IDX) begin
      rdata_o = rf_i[raddr_i];
      rbusy_o = busy_i[raddr_i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wen_i && (waddr_i != ZERO_IDX) && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
      rbusy_o = 1'b0;
    end
`endif
  end

endmodule : regfile_rport

// File: rtl/regfile_sb.sv
// Integer register file with a single-bit busy scoreboard per register; x0 is
// hard-wired zero. Define REGFILE_BYPASS_EN for same-cycle writeback forwarding.
module regfile_sb
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NR_READ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic                          issue_ready,
  input  logic                          flush
);

  localparam int NREGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] rf_q [1:NREGS-1];
  logic [NREGS-1:1]      busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rf_view [NREGS];
  logic [NREGS-1:0]      busy_view;
  logic                  wr_en;
  logic                  issue_fire;

  assign wr_en      = wen && (waddr != ZERO_IDX);
  assign issue_fire = issue_valid && issue_ready;
  assign busy_view  = {busy_q, 1'b0};

  always_comb begin
    rf_view[0] = '0;
    for (int r = 1; r < NREGS; r++) rf_view[r] = rf_q[r];
  end

  always_comb begin
    issue_ready = (issue_rd == ZERO_IDX) || !busy_view[issue_rd];
`ifdef REGFILE_BYPASS_EN
    if (wen && (waddr == issue_rd) && !flush) issue_ready = 1'b1;
`endif
  end

  // Flush beats everything; otherwise an issue to the retiring index wins
  // because its set is applied after the writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_en && (waddr == ADDR_WIDTH'(r)))         busy_d[r] = 1'b0;
        if (issue_fire && (issue_rd == ADDR_WIDTH'(r))) busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      // NOTE: the data array is reset too, since reads must return zero after reset.
      for (int r = 1; r < NREGS; r++) rf_q[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      busy_q <= busy_d;
      for (int r = 1; r < NREGS; r++) begin
        if (wr_en && (waddr == ADDR_WIDTH'(r))) rf_q[r] <= wdata;
      end
    end
  end

  for (genvar i = 0; i < NR_READ; i++) begin : g_rport
    regfile_rport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rport (
      .raddr_i (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .rf_i    (rf_view),
      .busy_i  (busy_view),
`ifdef REGFILE_BYPASS_EN
      .wen_i   (wen),
      .waddr_i (waddr),
      .wdata_i (wdata),
`endif
      .rdata_o (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .rbusy_o (rbusy[i])
    );
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected values, a negedge
// monitor compares them. Expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;
  import npc_pkg::*;

  localparam int AW  = 5;
  localparam int DW  = 64;
  localparam int DW3 = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wen, issue_valid, flush, issue_ready;
  reg_idx_t        waddr, issue_rd;
  logic [DW-1:0]   wdata;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]      rbusy;

  logic            wen3, issue_valid3, flush3, issue_ready3;
  reg_idx_t        waddr3, issue_rd3;
  logic [DW3-1:0]  wdata3;
  logic [3*AW-1:0] raddr3;
  logic [3*DW3-1:0] rdata3;
  logic [2:0]      rbusy3;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk (clk), .rst (rst), .wen (wen), .waddr (waddr), .wdata (wdata),
    .raddr (raddr), .rdata (rdata), .rbusy (rbusy),
    .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_ready (issue_ready),
    .flush (flush)
  );

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW3), .NR_READ(3)) dut3 (
    .clk (clk), .rst (rst), .wen (wen3), .waddr (waddr3), .wdata (wdata3),
    .raddr (raddr3), .rdata (rdata3), .rbusy (rbusy3),
    .issue_valid (issue_valid3), .issue_rd (issue_rd3), .issue_ready (issue_ready3),
    .flush (flush3)
  );

  typedef enum int {K_RD0, K_RD1, K_BUSY, K_READY, K_P0, K_P1, K_P2, K_BUSY3} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [63:0] actual(kind_e k);
    case (k)
      K_RD0:   return rdata[63:0];
      K_RD1:   return rdata[127:64];
      K_BUSY:  return 64'(rbusy);
      K_READY: return 64'(issue_ready);
      K_P0:    return 64'(rdata3[31:0]);
      K_P1:    return 64'(rdata3[63:32]);
      K_P2:    return 64'(rdata3[95:64]);
      K_BUSY3: return 64'(rbusy3);
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e   = exp_q.pop_front();
      act = actual(e.kind);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end
    end
  end

  task automatic chk(input string n, input kind_e k, input logic [63:0] v);
    exp_t e;
    e = '{name: n, kind: k, val: v};
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; issue_valid = 1'b0; flush = 1'b0; wen3 = 1'b0;
  endtask

  task automatic rd(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  localparam logic [63:0] V5  = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] V9  = 64'h12345678_9ABCDEF0;
  localparam logic [63:0] V11 = 64'h0F0F0F0F_A5A5A5A5;

  initial begin
    rst = 1'b1; idle();
    waddr = '0; wdata = '0; issue_rd = '0; raddr = '0;
    waddr3 = '0; wdata3 = '0; issue_rd3 = '0; raddr3 = '0;
    issue_valid3 = 1'b0; flush3 = 1'b0;
    #1;
    rd(5, 4); issue_rd = 5'd5;
    chk("reset rdata0", K_RD0, 64'd0);
    chk("reset rbusy", K_BUSY, 64'd0);
    chk("reset ready", K_READY, 64'd1);
    cyc(); cyc(); rst = 1'b0;

    cyc(); wen = 1'b1; waddr = 5'd5; wdata = V5; rd(0, 0);
    chk("x0 read", K_RD0, 64'd0);
    cyc(); waddr = 5'd0; wdata = '1; rd(5, 5);
    chk("x5 port0", K_RD0, V5);
    chk("x5 port1", K_RD1, V5);
    cyc(); idle(); rd(0, 0);
    chk("x0 write ignored p0", K_RD0, 64'd0);
    chk("x0 write ignored p1", K_RD1, 64'd0);

    cyc(); issue_valid = 1'b1; issue_rd = 5'd7; rd(7, 0);
    chk("x7 ready before issue", K_READY, 64'd1);
    chk("x7 not busy before issue", K_BUSY, 64'd0);
    cyc(); idle();
    chk("x7 busy after issue", K_BUSY, 64'd1);
    chk("x7 ready after issue", K_READY, 64'd0);
    cyc(); wen = 1'b1; waddr = 5'd7; wdata = 64'd3; rd(8, 0); issue_rd = 5'd0;
    chk("x0 always ready", K_READY, 64'd1);
    cyc(); idle(); rd(7, 0); issue_rd = 5'd7;
    chk("x7 busy cleared", K_BUSY, 64'd0);
    chk("x7 writeback data", K_RD0, 64'd3);
    chk("x7 ready after wb", K_READY, 64'd1);

    cyc(); issue_valid = 1'b1; issue_rd = 5'd9; wen = 1'b1; waddr = 5'd9; wdata = V9; rd(0, 0);
    chk("x9 ready pre-collision", K_READY, 64'd1);
    cyc(); idle(); rd(9, 0);
    chk("collision data", K_RD0, V9);
    chk("collision busy set wins", K_BUSY, 64'd1);
    chk("collision ready", K_READY, 64'd0);

    cyc(); flush = 1'b1; wen = 1'b1; waddr = 5'd11; wdata = V11; rd(0, 0);
    chk("x9 ready during flush", K_READY, 64'd0);
    cyc(); wen = 1'b0; flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd9; rd(9, 11);
    chk("flush cleared busy", K_BUSY, 64'd0);
    chk("flush ready", K_READY, 64'd1);
    chk("flush keeps data", K_RD0, V9);
    chk("write during flush", K_RD1, V11);
    cyc(); idle();
    chk("flush beats issue busy", K_BUSY, 64'd0);
    chk("flush beats issue ready", K_READY, 64'd1);

    cyc(); issue_valid = 1'b1; issue_rd = 5'd4; rd(0, 0);
    chk("x4 ready", K_READY, 64'd1);
    cyc(); idle(); rd(5, 4);
    chk("x4 busy on port1", K_BUSY, 64'd2);
    chk("x4 old data", K_RD1, 64'd0);
    chk("x5 port0 stable", K_RD0, V5);
    cyc(); wen = 1'b1; waddr = 5'd4; wdata = 64'h55;
    chk("bypass rdata1", K_RD1, BYP ? 64'h55 : 64'd0);
    chk("bypass rbusy", K_BUSY, BYP ? 64'd0 : 64'd2);
    chk("bypass ready", K_READY, BYP ? 64'd1 : 64'd0);
    chk("bypass other port", K_RD0, V5);
    cyc(); idle();
    chk("x4 after wb data", K_RD1, 64'h55);
    chk("x4 after wb busy", K_BUSY, 64'd0);
    chk("x4 after wb ready", K_READY, 64'd1);

    cyc(); wen = 1'b1; waddr = 5'd6; wdata = 64'h77; issue_valid = 1'b1; issue_rd = 5'd6;
    rd(5, 4); rst = 1'b1;
    chk("midrun reset x5", K_RD0, 64'd0);
    chk("midrun reset x4", K_RD1, 64'd0);
    chk("midrun reset busy", K_BUSY, 64'd0);
    chk("midrun reset ready", K_READY, 64'd1);
    cyc(); idle();
    cyc(); rst = 1'b0;
    for (int a = 1; a < 32; a += 2) begin
      cyc(); rd(a, (a == 31) ? 31 : a + 1);
      chk($sformatf("post-reset x%0d", a), K_RD0, 64'd0);
      chk($sformatf("post-reset x%0d", (a == 31) ? 31 : a + 1), K_RD1, 64'd0);
      chk($sformatf("post-reset busy x%0d", a), K_BUSY, 64'd0);
    end

    cyc(); wen3 = 1'b1; waddr3 = 5'd1; wdata3 = 32'hA000_0001;
    cyc(); waddr3 = 5'd2; wdata3 = 32'hB000_0002;
    cyc(); waddr3 = 5'd3; wdata3 = 32'hC000_0003;
    cyc(); wen3 = 1'b0; raddr3 = {5'd3, 5'd2, 5'd1};
    chk("nr3 p0 x1", K_P0, 64'hA000_0001);
    chk("nr3 p1 x2", K_P1, 64'hB000_0002);
    chk("nr3 p2 x3", K_P2, 64'hC000_0003);
    chk("nr3 busy", K_BUSY3, 64'd0);
    cyc(); raddr3 = {5'd2, 5'd1, 5'd3};
    chk("nr3 perm p0 x3", K_P0, 64'hC000_0003);
    chk("nr3 perm p1 x1", K_P1, 64'hA000_0001);
    chk("nr3 perm p2 x2", K_P2, 64'hB000_0002);
    cyc(); raddr3 = {5'd0, 5'd3, 5'd1};
    chk("nr3 zero p0 x1", K_P0, 64'hA000_0001);
    chk("nr3 zero p1 x3", K_P1, 64'hC000_0003);
    chk("nr3 zero p2 x0", K_P2, 64'd0);

    cyc(); idle();
    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register busy scoreboard, for the NPC pipeline's decode/writeback stages. It provides NR_READ combinational read ports, one synchronous write port, and a busy bit per architectural register that is set when an instruction issues with that destination and cleared on writeback. Register 0 is hard-wired to zero and never busy. Decode uses the per-port busy flags to stall on RAW hazards and `issue_ready` to stall on WAW hazards.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH
- DATA_WIDTH, 64, register data width
- NR_READ, 2, number of read ports (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wen  in  1  writeback strobe
- waddr  in  ADDR_WIDTH  writeback index
- wdata  in  DATA_WIDTH  writeback data
- raddr  in  NR_READ*ADDR_WIDTH  read indices; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NR_READ*DATA_WIDTH  read data, same packing
- rbusy  out  NR_READ  port i's register has a pending write
- issue_valid  in  1  decode requests to mark issue_rd busy
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction
- issue_ready  out  1  issue_rd is not busy (index 0 is always ready)
- flush  in  1  clear all busy bits (pipeline squash)

## Operation
- Storage: NREGS-1 data registers (index 0 not stored) and NREGS-1 busy bits.
- Read: rdata[i] = 0 if raddr[i]==0, else rf[raddr[i]]. rbusy[i] = busy[raddr[i]]; always 0 for index 0.
- Write: on the clk edge with wen && waddr!=0, rf[waddr] <= wdata and busy[waddr] <= 0. wen with waddr==0 is ignored.
- Issue handshake: the issue fires when issue_valid && issue_ready. On the edge it sets busy[issue_rd] <= 1. No effect when issue_rd==0.
- issue_ready = (issue_rd==0) || !busy[issue_rd]. It is combinational and independent of issue_valid.
- Issue and writeback to the same index in one cycle: the set wins and busy stays 1. A new producer supersedes the retiring one.
- Flush: on the edge, all busy bits are cleared. Data is untouched. A wen in the same cycle still writes. An issue in the same cycle is discarded, so flush wins over set.
- Busy tracking is a single bit, not a count. The WAW stall via issue_ready guarantees at most one outstanding producer per register.

## Timing
- Reset (asynchronous assert): all rf entries = 0 and all busy = 0. Consequently rdata = 0, rbusy = 0 and issue_ready = 1 while rst is high and after it is released.
- Read latency is 0 cycles (combinational). Write-to-read visibility is 1 cycle without bypass.
- A busy bit set at edge N is visible on rbusy/issue_ready in cycle N+1. A busy bit cleared at edge N is likewise visible in cycle N+1 (see the bypass option below).
- rst asserted mid-operation discards pending writes and issues immediately. No edge is needed.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wen && waddr!=0 && waddr==raddr[i], rdata[i] = wdata and rbusy[i] = 0 in the same cycle.
  - Any other port reading a different index is unaffected.
  - issue_ready is also forced to 1 when wen && waddr==issue_rd, unless flush is asserted.
- Undefined: no forwarding. rdata shows the old value and rbusy remains 1 until the cycle after the write.

## Structure
- A shared package `npc_pkg` holds:
  - the ADDR_WIDTH/DATA_WIDTH defaults (5/64)
  - the zero-register index constant
  - a `reg_idx_t` typedef
- One sub-module, `regfile_rport`: a single read port containing the zero mux, busy lookup and optional bypass mux. It is instantiated NR_READ times in a generate loop.
- The write, busy and flush logic stays in the top module.

## Test plan
- Reset: assert rst mid-run after writes. All rdata read 0 for indices 1..31, rbusy=0 and issue_ready=1.
- Basic write/read: write 64'hDEADBEEF_CAFEF00D to x5, read x5 on both ports next cycle → that value. Write to x0 → x0 still reads 0.
- Scoreboard: issue rd=7, then raddr0=7 → rbusy[0]=1 and issue_ready=0 for rd=7. Writeback x7=3 → next cycle rbusy[0]=0 and rdata0=3.
- Collision: issue rd=9 and wen x9 in the same cycle → x9 data updated, busy[9]=1 afterwards. Issue rd=9 with flush → busy[9]=0.
- Bypass (REGFILE_BYPASS_EN): with x4 busy, wen x4=0x55 while raddr1=4 → same-cycle rdata1=0x55 and rbusy[1]=0. Without the macro → old value and rbusy[1]=1 that cycle.
- NR_READ=3, DATA_WIDTH=32: three ports read distinct registers concurrently with correct packing.
